imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Parametrised, pipelined immediate generator for the RV32I/RV64I decode stage. It extracts and sign-extends the immediate of every base-ISA format: I, S, B, U and J. It flags unsupported opcodes and keeps a saturating count of them. A valid/ready handshake with a two-entry skid buffer sits on the output, so the block can stall against the ID/EX pipeline register without losing instructions.

## Interface
- XLEN, 32: datapath width; legal values are 32 and 64.
- CNT_W, 8: width of the illegal-opcode counter.
- clk_i  input  1  single clock; all state changes on its rising edge.
- rst_i  input  1  synchronous, active-high reset.
- valid_i  input  1  instr_i holds a valid instruction.
- ready_o  output  1  block can accept an instruction this cycle.
- instr_i  input  32  raw instruction word.
- valid_o  output  1  imm_o, type_o and illegal_o are valid.
- ready_i  input  1  downstream consumes the output this cycle.
- imm_o  output  XLEN  sign-extended immediate.
- type_o  output  3  format code: 0 NONE (R-type), 1 I, 2 S, 3 B, 4 U, 5 J.
- illegal_o  output  1  opcode not recognised.
- illegal_cnt_o  output  CNT_W  count of accepted illegal instructions; saturates.

## Operation
- Opcode decode on instr_i[6:0]:
  - 0110011 → NONE.
  - 0010011, 0000011, 1100111, 1110011 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - XLEN=64 only: 0011011 → I and 0111011 → NONE. With XLEN=32 these two opcodes are illegal.
  - Any other opcode: illegal_o=1, type NONE, imm 0.
- Immediates, all sign-extended from instr[31] to XLEN:
  - NONE: 0.
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - U: {instr[31:12], 12'b0}.
  - B (halfword units): {instr[31], instr[7], instr[30:25], instr[11:8]}.
  - J (halfword units): {instr[31], instr[19:12], instr[20], instr[30:21]}.
- Handshake:
  - Input transfer when valid_i && ready_o. Output transfer when valid_o && ready_i.
  - Storage is an output register (OR) plus one skid entry (SK). Effective states are EMPTY, ONE (OR only) and FULL (OR+SK).
  - Accepted instruction while OR is empty or draining → written to OR. Otherwise → written to SK.
  - On OR drain with SK valid → SK moves to OR and SK clears.
  - ready_o = !rst_i && !SK_valid. It has no combinational path from valid_i or ready_i.
  - Order is strictly preserved. No instruction is dropped or duplicated.
- Counter:
  - illegal_cnt_o increments by 1 on each input transfer whose opcode is illegal.
  - It holds at 2^CNT_W−1. There is no wrap-around.

## Timing
- Latency is 1 cycle: an instruction accepted in cycle N appears on imm_o/valid_o in cycle N+1 when OR is free.
- Throughput is 1 instruction/cycle while ready_i stays high.
- FULL, with ready_i low: ready_o=0, and valid_i/instr_i are ignored.
- FULL, with ready_i high: OR drains and SK shifts into OR in the same edge. ready_o returns to 1 the cycle after.
- ONE, with simultaneous input and output transfer: the new instruction goes into OR and SK stays empty.
- Outputs are stable while valid_o && !ready_i.
- Reset (valid in any cycle, including mid-stall):
  - Next edge: valid_o=0, imm_o=0, type_o=0, illegal_o=0, illegal_cnt_o=0, SK cleared.
  - ready_o is 0 while rst_i=1 and 1 in the first cycle after release.
  - In-flight instructions are discarded.

## Configuration
- IMM_GEN_BYTE_OFFSET_EN:
  - Defined: B and J immediates are byte offsets, i.e. the halfword value shifted left 1 with bit 0 = 0, ready for direct PC addition.
  - Undefined: B and J use the legacy halfword encoding above, and the datapath applies the shift.
  - I, S, U and NONE are unaffected.

## Test plan
- I and S decode, XLEN=32, ready_i=1:
  - 0xFFF00093 (addi x1,x0,-1) → next cycle imm_o=0xFFFFFFFF, type_o=1.
  - 0xFE112E23 (sw x1,-4(x2)) → imm_o=0xFFFFFFFC, type_o=2.
- B decode, 0xFE000CE3 (beq −8):
  - Macro undefined → imm_o=0xFFFFFFFC, type_o=3.
  - IMM_GEN_BYTE_OFFSET_EN defined → 0xFFFFFFF8.
- U and XLEN=64:
  - 0x123450B7 (lui) → imm_o=0x12345000, type_o=4.
  - Same with XLEN=64 and instr bit 31 set (0x800000B7) → imm_o=0xFFFFFFFF80000000.
- Backpressure:
  - Hold ready_i=0 and offer A, B, C back-to-back with valid_i=1.
  - A is accepted into OR and B into SK. ready_o=0 from the cycle after B, and C is held.
  - Raise ready_i → outputs A, B, C in consecutive cycles. No loss or duplication.
- Illegal opcode with CNT_W=2:
  - Accept 0x0000007F five times → each output has illegal_o=1, imm_o=0, type_o=0.
  - illegal_cnt_o goes 1, 2, 3, 3, 3.
- Reset in FULL state:
  - Assert rst_i for 1 cycle.
  - Next cycle: valid_o=0 and illegal_cnt_o=0, with ready_o=0 while rst_i=1.
  - After release: ready_o=1, and the stale A and B never appear.

Source files
------------

// File: rtl/imm_gen_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe_if
// Brief    : Handshake and result bundle for imm_gen_pipe. The slave modport
//            is the generator's view; the master modport is the view of the
//            decode stage feeding it and the ID/EX register draining it.
// Revision : 1.0 - initial release
// ============================================================================
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
);
  logic             valid_i;
  logic             ready_o;
  logic [31:0]      instr_i;
  logic             valid_o;
  logic             ready_i;
  logic [XLEN-1:0]  imm_o;
  logic [2:0]       type_o;
  logic             illegal_o;
  logic [CNT_W-1:0] illegal_cnt_o;

  modport slave (
    input  valid_i, instr_i, ready_i,
    output ready_o, valid_o, imm_o, type_o, illegal_o, illegal_cnt_o
  );

  modport master (
    output valid_i, instr_i, ready_i,
    input  ready_o, valid_o, imm_o, type_o, illegal_o, illegal_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe
// Brief    : Pipelined RV32I/RV64I immediate generator with illegal-opcode
//            flag, saturating illegal counter and a two-entry skid buffer
//            (output register + skid entry) on a valid/ready output.
// Config   : IMM_GEN_BYTE_OFFSET_EN - when defined, B/J immediates are byte
//            offsets (halfword value << 1); otherwise halfword units.
// Revision : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  wire            clk_i,
  input  wire            rst_i,
  imm_gen_pipe_if.slave  bus
);

  localparam logic [6:0] c_op_reg    = 7'b0110011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_system = 7'b1110011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_imm32  = 7'b0011011;
  localparam logic [6:0] c_op_reg32  = 7'b0111011;

  localparam logic [2:0] c_type_none = 3'd0;
  localparam logic [2:0] c_type_i    = 3'd1;
  localparam logic [2:0] c_type_s    = 3'd2;
  localparam logic [2:0] c_type_b    = 3'd3;
  localparam logic [2:0] c_type_u    = 3'd4;
  localparam logic [2:0] c_type_j    = 3'd5;

  localparam bit             c_rv64    = (XLEN == 64);
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic [31:0]      w_instr;
  logic [2:0]       w_type;
  logic             w_illegal;
  logic [XLEN-1:0]  w_imm;
  logic             w_in_xfer;
  logic             w_out_xfer;

  logic             r_or_valid;
  logic [XLEN-1:0]  r_or_imm;
  logic [2:0]       r_or_type;
  logic             r_or_illegal;
  logic             r_sk_valid;
  logic [XLEN-1:0]  r_sk_imm;
  logic [2:0]       r_sk_type;
  logic             r_sk_illegal;
  logic [CNT_W-1:0] r_cnt;

  assign w_instr = bus.instr_i;

  // Ready depends only on reset and skid occupancy, never on valid_i/ready_i.
  assign bus.ready_o = !rst_i && !r_sk_valid;
  assign w_in_xfer   = bus.valid_i && bus.ready_o;
  assign w_out_xfer  = r_or_valid && bus.ready_i;

  // Opcode classification; the *W opcodes exist only on RV64.
  always_comb begin
    w_type    = c_type_none;
    w_illegal = 1'b0;
    case (w_instr[6:0])
      c_op_reg:                                      w_type = c_type_none;
      c_op_imm, c_op_load, c_op_jalr, c_op_system:   w_type = c_type_i;
      c_op_store:                                    w_type = c_type_s;
      c_op_branch:                                   w_type = c_type_b;
      c_op_lui, c_op_auipc:                          w_type = c_type_u;
      c_op_jal:                                      w_type = c_type_j;
      c_op_imm32: begin
        if (c_rv64) w_type = c_type_i;
        else        w_illegal = 1'b1;
      end
      c_op_reg32: begin
        if (!c_rv64) w_illegal = 1'b1;
      end
      default:                                       w_illegal = 1'b1;
    endcase
  end

  // Immediate assembly; signed casts sign-extend from instr[31] to XLEN.
  always_comb begin
    w_imm = '0;
    case (w_type)
      c_type_i: w_imm = XLEN'($signed(w_instr[31:20]));
      c_type_s: w_imm = XLEN'($signed({w_instr[31:25], w_instr[11:7]}));
      c_type_u: w_imm = XLEN'($signed({w_instr[31:12], 12'b0}));
`ifdef IMM_GEN_BYTE_OFFSET_EN
      c_type_b: w_imm = XLEN'($signed({w_instr[31], w_instr[7], w_instr[30:25],
                                       w_instr[11:8], 1'b0}));
      c_type_j: w_imm = XLEN'($signed({w_instr[31], w_instr[19:12], w_instr[20],
                                       w_instr[30:21], 1'b0}));
`else
      c_type_b: w_imm = XLEN'($signed({w_instr[31], w_instr[7], w_instr[30:25],
                                       w_instr[11:8]}));
      c_type_j: w_imm = XLEN'($signed({w_instr[31], w_instr[19:12], w_instr[20],
                                       w_instr[30:21]}));
`endif
      default:  w_imm = '0;
    endcase
  end

  // Output register and skid entry: OR takes new data whenever it is empty
  // or draining; a pending skid entry always has priority so order holds.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_or_valid   <= 1'b0;
      r_or_imm     <= '0;
      r_or_type    <= c_type_none;
      r_or_illegal <= 1'b0;
      r_sk_valid   <= 1'b0;
      r_sk_imm     <= '0;
      r_sk_type    <= c_type_none;
      r_sk_illegal <= 1'b0;
    end else if (w_out_xfer || !r_or_valid) begin
      if (r_sk_valid) begin
        r_or_valid   <= 1'b1;
        r_or_imm     <= r_sk_imm;
        r_or_type    <= r_sk_type;
        r_or_illegal <= r_sk_illegal;
        r_sk_valid   <= 1'b0;
      end else if (w_in_xfer) begin
        r_or_valid   <= 1'b1;
        r_or_imm     <= w_imm;
        r_or_type    <= w_type;
        r_or_illegal <= w_illegal;
      end else begin
        r_or_valid   <= 1'b0;
      end
    end else if (w_in_xfer) begin
      r_sk_valid   <= 1'b1;
      r_sk_imm     <= w_imm;
      r_sk_type    <= w_type;
      r_sk_illegal <= w_illegal;
    end
  end

  // Saturating count of accepted illegal instructions.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_in_xfer && w_illegal && (r_cnt != c_cnt_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.valid_o       = r_or_valid;
  assign bus.imm_o         = r_or_imm;
  assign bus.type_o        = r_or_type;
  assign bus.illegal_o     = r_or_illegal;
  assign bus.illegal_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_gen_pipe
// Brief    : Directed self-checking bench for imm_gen_pipe. Instance u_dut_a
//            is RV32 with an 8-bit counter, u_dut_b is RV64 with a 2-bit
//            counter. Honours IMM_GEN_BYTE_OFFSET_EN for B/J expectations.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .CNT_W(8)) if_a ();
  imm_gen_pipe_if #(.XLEN(64), .CNT_W(2)) if_b ();

  imm_gen_pipe #(.XLEN(32), .CNT_W(8)) u_dut_a (.clk_i(clk), .rst_i(rst), .bus(if_a.slave));
  imm_gen_pipe #(.XLEN(64), .CNT_W(2)) u_dut_b (.clk_i(clk), .rst_i(rst), .bus(if_b.slave));

`ifdef IMM_GEN_BYTE_OFFSET_EN
  localparam logic [63:0] c_exp_beq = 64'hFFFF_FFF8;
  localparam logic [63:0] c_exp_jal = 64'h8;
`else
  localparam logic [63:0] c_exp_beq = 64'hFFFF_FFFC;
  localparam logic [63:0] c_exp_jal = 64'h4;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [31:0] ins);
    if_a.valid_i = v;
    if_a.instr_i = ins;
  endtask

  task automatic check_a(input string tag, input logic [31:0] imm, input logic [2:0] typ,
                         input logic ill);
    check({tag, ".valid"}, 64'(if_a.valid_o), 64'd1);
    check({tag, ".imm"},   64'(if_a.imm_o), imm);
    check({tag, ".type"},  64'(if_a.type_o), 64'(typ));
    check({tag, ".ill"},   64'(if_a.illegal_o), 64'(ill));
  endtask

  initial begin
    if_a.valid_i = 1'b0; if_a.instr_i = '0; if_a.ready_i = 1'b1;
    if_b.valid_i = 1'b0; if_b.instr_i = '0; if_b.ready_i = 1'b1;

    // Reset state
    tick(); tick();
    check("rst.ready",  64'(if_a.ready_o), 64'd0);
    check("rst.valid",  64'(if_a.valid_o), 64'd0);
    check("rst.imm",    64'(if_a.imm_o), 64'd0);
    check("rst.cnt",    64'(if_a.illegal_cnt_o), 64'd0);
    rst = 1'b0;
    #1;
    check("rel.ready",  64'(if_a.ready_o), 64'd1);

    // Streaming decode, one per cycle, ready_i high
    drive_a(1'b1, 32'hFFF0_0093); tick(); check_a("addi", 32'hFFFF_FFFF, 3'd1, 1'b0);
    drive_a(1'b1, 32'hFE11_2E23); tick(); check_a("sw",   32'hFFFF_FFFC, 3'd2, 1'b0);
    drive_a(1'b1, 32'hFE00_0CE3); tick(); check_a("beq",  c_exp_beq[31:0], 3'd3, 1'b0);
    drive_a(1'b1, 32'h1234_50B7); tick(); check_a("lui",  32'h1234_5000, 3'd4, 1'b0);
    drive_a(1'b1, 32'h0080_006F); tick(); check_a("jal",  c_exp_jal[31:0], 3'd5, 1'b0);
    drive_a(1'b1, 32'h0020_81B3); tick(); check_a("add",  32'h0, 3'd0, 1'b0);
    drive_a(1'b1, 32'h0010_009B); tick(); check_a("addiw32", 32'h0, 3'd0, 1'b1);
    check("addiw32.cnt", 64'(if_a.illegal_cnt_o), 64'd1);
    drive_a(1'b0, 32'h0); tick();
    check("idle.valid", 64'(if_a.valid_o), 64'd0);

    // Backpressure: A, B, C offered with ready_i low
    if_a.ready_i = 1'b0;
    drive_a(1'b1, 32'h0010_0093);
    check("bp.rdyA", 64'(if_a.ready_o), 64'd1);
    tick();
    drive_a(1'b1, 32'h0020_0093);
    check("bp.rdyB", 64'(if_a.ready_o), 64'd1);
    tick();
    check("bp.full_rdy", 64'(if_a.ready_o), 64'd0);
    check_a("bp.holdA", 32'h1, 3'd1, 1'b0);
    drive_a(1'b1, 32'h0030_0093);
    tick();
    check("bp.stall_rdy", 64'(if_a.ready_o), 64'd0);
    check_a("bp.stableA", 32'h1, 3'd1, 1'b0);
    if_a.ready_i = 1'b1;
    tick();
    check_a("bp.outB", 32'h2, 3'd1, 1'b0);
    check("bp.rdy_back", 64'(if_a.ready_o), 64'd1);
    tick();
    drive_a(1'b0, 32'h0);
    check_a("bp.outC", 32'h3, 3'd1, 1'b0);
    tick();
    check("bp.drained", 64'(if_a.valid_o), 64'd0);

    // RV64 instance: sign-extended U and W-opcode decode
    if_b.valid_i = 1'b1; if_b.instr_i = 32'h8000_00B7; tick();
    check("b.lui.imm",  if_b.imm_o, 64'hFFFF_FFFF_8000_0000);
    check("b.lui.type", 64'(if_b.type_o), 64'd4);
    if_b.instr_i = 32'h0010_009B; tick();
    check("b.addiw.imm",  if_b.imm_o, 64'd1);
    check("b.addiw.type", 64'(if_b.type_o), 64'd1);
    check("b.addiw.ill",  64'(if_b.illegal_o), 64'd0);

    // Illegal opcode five times, counter saturates at 3
    if_b.instr_i = 32'h0000_007F;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("b.ill%0d.ill", i),  64'(if_b.illegal_o), 64'd1);
      check($sformatf("b.ill%0d.imm", i),  if_b.imm_o, 64'd0);
      check($sformatf("b.ill%0d.type", i), 64'(if_b.type_o), 64'd0);
      check($sformatf("b.ill%0d.cnt", i),  64'(if_b.illegal_cnt_o), (i < 3) ? 64'(i + 1) : 64'd3);
    end
    if_b.valid_i = 1'b0;

    // Reset while FULL
    if_a.ready_i = 1'b0;
    drive_a(1'b1, 32'h0040_0093); tick();
    drive_a(1'b1, 32'h0050_0093); tick();
    check("rf.full", 64'(if_a.ready_o), 64'd0);
    rst = 1'b1;
    #1;
    check("rf.rdy_in_rst", 64'(if_a.ready_o), 64'd0);
    tick();
    check("rf.valid", 64'(if_a.valid_o), 64'd0);
    check("rf.cnt_a", 64'(if_a.illegal_cnt_o), 64'd0);
    check("rf.cnt_b", 64'(if_b.illegal_cnt_o), 64'd0);
    check("rf.rdy",   64'(if_a.ready_o), 64'd0);
    rst = 1'b0;
    drive_a(1'b0, 32'h0);
    if_a.ready_i = 1'b1;
    #1;
    check("rf.rdy_rel", 64'(if_a.ready_o), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rf.stale%0d", i), 64'(if_a.valid_o), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
